// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM with byte-lane writes, a zero-fill sweep after reset and a 1- or 2-stage read pipeline.
// Optional macro BRAM_WRITE_FORWARD_EN: a same-address collision returns the byte-merged new word instead of the old one.
module bram_sdp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ram_enable,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic [ADDR_WIDTH-1:0]   wr_address,
    input  logic [DATA_WIDTH-1:0]   input_data,
    input  logic                    read_enable,
    input  logic [ADDR_WIDTH-1:0]   rd_address,
    output logic [DATA_WIDTH-1:0]   output_data,
    output logic                    output_valid,
    output logic                    ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_ptr_q, fill_ptr_d;
    logic                    ready_q, ready_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_fire, rd_fire;
    logic [LANES-1:0]        lane_we;
    logic [ADDR_WIDTH-1:0]   wa;
    logic [DATA_WIDTH-1:0]   wd;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [DATA_WIDTH-1:0]   stage_data_q, stage_data_d;
    logic                    stage_valid_q, stage_valid_d;

    assign wr_fire = ram_enable & write_enable & ready_q;
    assign rd_fire = ram_enable & read_enable & ready_q;
    assign ready   = ready_q;

    // The fill sweep owns the write port during INIT; user writes only reach it in RUN.
    always_comb begin
        state_d    = state_q;
        fill_ptr_d = fill_ptr_q;
        ready_d    = ready_q;
        lane_we    = '0;
        wa         = wr_address;
        wd         = input_data;
        case (state_q)
            ST_INIT: begin
                lane_we    = '1;
                wa         = fill_ptr_q;
                wd         = '0;
                fill_ptr_d = fill_ptr_q + 1'b1;
                if (fill_ptr_q == '1) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_fire) begin
                    lane_we = byte_enable;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            fill_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_ptr_q <= fill_ptr_d;
            ready_q    <= ready_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                mem[wa][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Array read stage; non-blocking array update makes a collision read-first by default.
    always_comb begin
        rd_word = mem[rd_address];
`ifdef BRAM_WRITE_FORWARD_EN
        if (wr_fire && (wr_address == rd_address)) begin
            for (int i = 0; i < LANES; i++) begin
                if (byte_enable[i]) begin
                    rd_word[8*i +: 8] = input_data[8*i +: 8];
                end
            end
        end
`endif
    end

    always_comb begin
        stage_valid_d = rd_fire;
        stage_data_d  = rd_fire ? rd_word : stage_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
            logic                  out_valid_q, out_valid_d;

            always_comb begin
                out_valid_d = stage_valid_q;
                out_data_d  = stage_valid_q ? stage_data_q : out_data_q;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_data_q  <= out_data_d;
                end
            end

            assign output_data  = out_data_q;
            assign output_valid = out_valid_q;
        end else begin : g_lat1
            assign output_data  = stage_data_q;
            assign output_valid = stage_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp.sv
// Directed self-checking bench for bram_sdp: fill sweep, byte lanes, collisions, pipelining, enable gating, reset.
module tb_bram_sdp;
    localparam int LAT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ram_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  byte_enable = 4'h0;
    logic [8:0]  wr_address = '0;
    logic [31:0] input_data = '0;
    logic        read_enable = 1'b0;
    logic [8:0]  rd_address = '0;
    logic [31:0] output_data;
    logic        output_valid;
    logic        ready;

    int checks = 0;
    int failures = 0;

    bram_sdp #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (9),
        .READ_LATENCY(LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ram_enable  (ram_enable),
        .write_enable(write_enable),
        .byte_enable (byte_enable),
        .wr_address  (wr_address),
        .input_data  (input_data),
        .read_enable (read_enable),
        .rd_address  (rd_address),
        .output_data (output_data),
        .output_valid(output_valid),
        .ready       (ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Counts cycles until ready rises (bounded), plus any output_valid seen meanwhile.
    task automatic wait_ready(output int n, output int vcount);
        n = 0;
        vcount = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
            if (output_valid === 1'b1) vcount++;
        end
    endtask

    task automatic xfer(input logic do_wr, input logic [8:0] wa, input logic [31:0] wdat,
                        input logic [3:0] be, input logic do_rd, input logic [8:0] ra,
                        input logic [31:0] exp, input string tag);
        ram_enable   = 1'b1;
        write_enable = do_wr;
        wr_address   = wa;
        input_data   = wdat;
        byte_enable  = be;
        read_enable  = do_rd;
        rd_address   = ra;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        if (do_rd) begin
            repeat (LAT - 1) begin
                check({tag, "_early"}, {31'b0, output_valid}, 32'd0);
                @(posedge clock);
                #1;
            end
            check({tag, "_valid"}, {31'b0, output_valid}, 32'd1);
            check({tag, "_data"}, output_data, exp);
            @(posedge clock);
            #1;
            check({tag, "_pulse"}, {31'b0, output_valid}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int vc;
        int j;
        logic [8:0]  addrs [3];
        logic [31:0] exps  [3];
        logic [31:0] collide_exp;

        addrs[0] = 9'h010; exps[0] = 32'hDEADBEEF;
        addrs[1] = 9'h020; exps[1] = 32'h11BB33DD;
        addrs[2] = 9'h030; exps[2] = 32'hCAFEF00D;
`ifdef BRAM_WRITE_FORWARD_EN
        collide_exp = 32'hCAFEF00D;
`else
        collide_exp = 32'h12345678;
`endif

        // Reset state
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_valid", {31'b0, output_valid}, 32'd0);
        check("rst_data", output_data, 32'd0);

        // Requests held during INIT must be ignored
        ram_enable = 1'b1; write_enable = 1'b1; read_enable = 1'b1;
        wr_address = 9'h0AA; rd_address = 9'h0AA; input_data = 32'hFFFFFFFF; byte_enable = 4'hF;
        reset = 1'b0;
        wait_ready(n, vc);
        write_enable = 1'b0; read_enable = 1'b0;
        check("init_cycles", n, 32'd512);
        check("init_valid", vc, 32'd0);

        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h000, 32'h0, "zero_000");
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h1FF, 32'h0, "zero_1ff");
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h0AA, 32'h0, "zero_0aa");

        // Full-word write and readback
        xfer(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b0, 9'h0, 32'h0, "wr_010");
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h010, 32'hDEADBEEF, "rd_010");

        // Byte-lane merge, plus a no-op write with no lanes enabled
        xfer(1'b1, 9'h020, 32'h11223344, 4'hF, 1'b0, 9'h0, 32'h0, "wr_020a");
        xfer(1'b1, 9'h020, 32'hAABBCCDD, 4'b0101, 1'b0, 9'h0, 32'h0, "wr_020b");
        xfer(1'b1, 9'h020, 32'h55555555, 4'b0000, 1'b0, 9'h0, 32'h0, "wr_020c");
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h020, 32'h11BB33DD, "rd_020");

        // Same-address collision
        xfer(1'b1, 9'h030, 32'h12345678, 4'hF, 1'b0, 9'h0, 32'h0, "wr_030");
        xfer(1'b1, 9'h030, 32'hCAFEF00D, 4'hF, 1'b1, 9'h030, collide_exp, "collide");
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h030, 32'hCAFEF00D, "rd_030");

        // Simultaneous write and read to different addresses
        xfer(1'b1, 9'h040, 32'h0BADF00D, 4'hF, 1'b1, 9'h010, 32'hDEADBEEF, "wr040_rd010");
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h040, 32'h0BADF00D, "rd_040");

        // Back-to-back reads
        ram_enable = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            if (i < 3) begin
                read_enable = 1'b1;
                rd_address  = addrs[i];
            end else begin
                read_enable = 1'b0;
            end
            @(posedge clock);
            #1;
            j = i - LAT + 1;
            if (j >= 0 && j < 3) begin
                check($sformatf("b2b%0d_valid", j), {31'b0, output_valid}, 32'd1);
                check($sformatf("b2b%0d_data", j), output_data, exps[j]);
            end else begin
                check($sformatf("b2b_idle%0d", i), {31'b0, output_valid}, 32'd0);
            end
        end
        read_enable = 1'b0;

        // ram_enable low gates both ports; output_data holds
        ram_enable = 1'b0; write_enable = 1'b1; read_enable = 1'b1;
        wr_address = 9'h010; input_data = 32'h0; byte_enable = 4'hF; rd_address = 9'h010;
        vc = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (output_valid === 1'b1) vc++;
        end
        write_enable = 1'b0; read_enable = 1'b0;
        check("dis_valid", vc, 32'd0);
        check("dis_hold", output_data, 32'hCAFEF00D);
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h010, 32'hDEADBEEF, "dis_mem");

        // Reset mid-INIT restarts the full sweep
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_ready(n, vc);
        check("reinit_cycles", n, 32'd512);

        // Reset during RUN with a read in flight
        xfer(1'b1, 9'h050, 32'hA5A5A5A5, 4'hF, 1'b0, 9'h0, 32'h0, "wr_050");
        ram_enable  = 1'b1;
        read_enable = 1'b1;
        rd_address  = 9'h050;
        @(posedge clock);
        #1;
        read_enable = 1'b0;
        reset = 1'b1;
        #1;
        check("runrst_ready", {31'b0, ready}, 32'd0);
        check("runrst_valid", {31'b0, output_valid}, 32'd0);
        check("runrst_data", output_data, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_ready(n, vc);
        check("runrst_cycles", n, 32'd512);
        check("runrst_novalid", vc, 32'd0);
        xfer(1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h050, 32'h0, "refill_050");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
